// File: rtl/cam_addr_alloc.sv
// Write-address allocator for the FIX parser CAM: tracks occupied entries, grants the
// lowest free one per request, releases entries and sweeps the whole CAM on flush.
module cam_addr_alloc #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic                  alloc_done,
  input  logic                  free_valid,
  input  logic [ADDR_WIDTH-1:0] free_addr,
  input  logic                  flush_i,
  output logic                  wr_en_o,
  output logic                  wr_clear_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  busy_o
);

  localparam logic [ADDR_WIDTH:0]   DepthCount = (ADDR_WIDTH + 1)'(CAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CountOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LastSweep  = ADDR_WIDTH'(CAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] SweepOne   = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [CAM_DEPTH-1:0]    bitmap_q, bitmap_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic                    wr_clear_q, wr_clear_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   free_idx;
  logic                    is_idle, is_full, alloc_go;

  assign is_idle     = (state_q == StIdle);
  assign is_full     = (count_q == DepthCount);
  assign alloc_ready = is_idle && !is_full && !free_valid && !flush_i;
  assign alloc_go    = alloc_valid && alloc_ready;

  // Lowest-index clear bit; scanning downward lets the lowest hit win.
  always_comb begin
    free_idx = '0;
    for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    count_d    = count_q;
    sweep_d    = sweep_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_clear_d = wr_clear_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StFlush;
          sweep_d = '0;
        end else if (free_valid) begin
          if (bitmap_q[free_addr]) begin
            bitmap_d[free_addr] = 1'b0;
            count_d             = count_q - CountOne;
            wr_en_d             = 1'b1;
            wr_clear_d          = 1'b1;
            addr_d              = free_addr;
          end
        end else if (alloc_go) begin
          bitmap_d[free_idx] = 1'b1;
          count_d            = count_q + CountOne;
          wr_en_d            = 1'b1;
          wr_clear_d         = 1'b0;
          addr_d             = free_idx;
          done_d             = 1'b1;
        end
      end
      StFlush: begin
        // Keep the count consistent with the bitmap while the sweep progresses.
        bitmap_d[sweep_q] = 1'b0;
        count_d           = count_q - {{ADDR_WIDTH{1'b0}}, bitmap_q[sweep_q]};
        addr_d            = sweep_q;
        wr_clear_d        = 1'b1;
        if (sweep_q == LastSweep) begin
          state_d  = StIdle;
          bitmap_d = '0;
          count_d  = '0;
        end else begin
          sweep_d = sweep_q + SweepOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bitmap_q   <= '0;
      count_q    <= '0;
      sweep_q    <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_clear_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      count_q    <= count_d;
      sweep_q    <= sweep_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_clear_q <= wr_clear_d;
      done_q     <= done_d;
    end
  end

  // Sweep writes come straight from the FLUSH state so they start the cycle after flush.
  assign busy_o     = (state_q == StFlush);
  assign wr_en_o    = busy_o || wr_en_q;
  assign wr_clear_o = busy_o || wr_clear_q;
  assign addr_o     = busy_o ? sweep_q : addr_q;
  assign alloc_done = done_q;
  assign count_o    = count_q;
  assign full_o     = is_full;
  assign empty_o    = (count_q == '0);

endmodule

// File: tb/tb_cam_addr_alloc.sv
// Self-checking bench for cam_addr_alloc: directed table and sequences plus random
// traffic checked against an occupancy-array reference model.
module tb_cam_addr_alloc;

  localparam int Depth = 32;

  logic       clk, rst_n;
  logic       alloc_valid, alloc_ready, alloc_done;
  logic       free_valid, flush_i;
  logic [4:0] free_addr;
  logic       wr_en_o, wr_clear_o;
  logic [4:0] addr_o;
  logic [5:0] count_o;
  logic       full_o, empty_o, busy_o;

  cam_addr_alloc #(.ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_done (alloc_done),
    .free_valid (free_valid),
    .free_addr  (free_addr),
    .flush_i    (flush_i),
    .wr_en_o    (wr_en_o),
    .wr_clear_o (wr_clear_o),
    .addr_o     (addr_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy array plus expected registered outputs.
  bit         occ [Depth];
  bit         m_busy;
  int         m_sweep;
  bit         e_wr_en, e_clr, e_done;
  int         e_addr;

  typedef struct {
    logic       av;
    logic       fv;
    logic [4:0] fa;
    logic       fl;
    logic       rdy;
    logic       we;
    logic       clr;
    logic [4:0] addr;
    logic       done;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < Depth; i++) n += int'(occ[i]);
    return n;
  endfunction

  function automatic bit m_ready(input bit fv, input bit fl);
    return !m_busy && (m_count() < Depth) && !fv && !fl;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < Depth; i++) occ[i] = 1'b0;
    m_busy = 0; m_sweep = 0;
    e_wr_en = 0; e_clr = 0; e_done = 0; e_addr = 0;
  endtask

  task automatic m_step(input bit av, input bit fv, input int fa, input bit fl);
    e_done = 0;
    if (m_busy) begin
      occ[m_sweep] = 1'b0;
      if (m_sweep == Depth - 1) begin
        m_busy  = 0;
        e_wr_en = 0;
        e_addr  = Depth - 1;
      end else begin
        m_sweep++;
        e_wr_en = 1; e_clr = 1; e_addr = m_sweep;
      end
    end else if (fl) begin
      m_busy = 1; m_sweep = 0;
      e_wr_en = 1; e_clr = 1; e_addr = 0;
    end else if (fv) begin
      if (occ[fa]) begin
        occ[fa] = 1'b0;
        e_wr_en = 1; e_clr = 1; e_addr = fa;
      end else begin
        e_wr_en = 0;
      end
    end else if (av && m_count() < Depth) begin
      int idx = 0;
      while (occ[idx]) idx++;
      occ[idx] = 1'b1;
      e_wr_en = 1; e_clr = 0; e_addr = idx; e_done = 1;
    end else begin
      e_wr_en = 0;
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", int'(wr_en_o), int'(e_wr_en));
    if (e_wr_en) chk("wr_clear", int'(wr_clear_o), int'(e_clr));
    chk("addr", int'(addr_o), e_addr);
    chk("alloc_done", int'(alloc_done), int'(e_done));
    chk("busy", int'(busy_o), int'(m_busy));
    if (!m_busy) begin
      chk("count", int'(count_o), m_count());
      chk("full", int'(full_o), int'(m_count() == Depth));
      chk("empty", int'(empty_o), int'(m_count() == 0));
    end
  endtask

  // One clock: drive, check alloc_ready before the edge, check outputs after it.
  task automatic cycle(input bit av, input bit fv, input int fa, input bit fl);
    alloc_valid = av; free_valid = fv; free_addr = 5'(fa); flush_i = fl;
    #1;
    chk("alloc_ready", int'(alloc_ready), int'(m_ready(fv, fl)));
    m_step(av, fv, fa, fl);
    @(posedge clk);
    #1;
    alloc_valid = 0; free_valid = 0; free_addr = '0; flush_i = 0;
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_wr_en", int'(wr_en_o), 0);
    chk("rst_wr_clear", int'(wr_clear_o), 0);
    chk("rst_done", int'(alloc_done), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_full", int'(full_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_addr", int'(addr_o), 0);
    chk("rst_count", int'(count_o), 0);
  endtask

  task automatic do_reset();
    alloc_valid = 0; free_valid = 0; free_addr = '0; flush_i = 0;
    rst_n = 0;
    m_reset();
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("rst_ready", int'(alloc_ready), 1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 6'd31};
    vecs[1] = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 6'd30};
    vecs[2] = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 6'd31};
    vecs[3] = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 6'd32};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 6'd32};
    vecs[5] = '{1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 6'd31};
    vecs[6] = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 6'd32};
    vecs[7] = '{1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 6'd31};
    vecs[8] = '{1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 6'd31};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 6'd31};

    do_reset();

    // Fill the CAM: grants 0..31 in order.
    for (int i = 0; i < Depth; i++) begin
      cycle(1, 0, 0, 0);
      chk("fill_addr", int'(addr_o), i);
      chk("fill_clear", int'(wr_clear_o), 0);
    end
    chk("fill_full", int'(full_o), 1);
    cycle(1, 0, 0, 0);
    chk("alloc33_no_write", int'(wr_en_o), 0);

    // Free / alloc / collision / unoccupied-free table.
    for (int v = 0; v < 10; v++) begin
      alloc_valid = vecs[v].av; free_valid = vecs[v].fv;
      free_addr = vecs[v].fa; flush_i = vecs[v].fl;
      #1;
      chk("tab_ready", int'(alloc_ready), int'(vecs[v].rdy));
      cycle(vecs[v].av, vecs[v].fv, int'(vecs[v].fa), vecs[v].fl);
      chk("tab_wr_en", int'(wr_en_o), int'(vecs[v].we));
      if (vecs[v].we) chk("tab_clear", int'(wr_clear_o), int'(vecs[v].clr));
      chk("tab_addr", int'(addr_o), int'(vecs[v].addr));
      chk("tab_done", int'(alloc_done), int'(vecs[v].done));
      chk("tab_count", int'(count_o), int'(vecs[v].cnt));
    end

    // Flush with a simultaneous alloc: full sweep, alloc dropped.
    cycle(1, 0, 0, 1);
    for (int k = 0; k < Depth; k++) begin
      chk("sweep_busy", int'(busy_o), 1);
      chk("sweep_addr", int'(addr_o), k);
      chk("sweep_clear", int'(wr_clear_o), 1);
      chk("sweep_ready", int'(alloc_ready), 0);
      cycle(1, 1, k, 1);
    end
    chk("post_flush_count", int'(count_o), 0);
    chk("post_flush_empty", int'(empty_o), 1);
    cycle(1, 0, 0, 0);
    chk("post_flush_grant", int'(addr_o), 0);

    // 10 allocs, flush, then reset at sweep address 12.
    for (int i = 1; i < 10; i++) cycle(1, 0, 0, 0);
    chk("ten_count", int'(count_o), 10);
    cycle(1, 0, 0, 1);
    for (int k = 0; k < 12; k++) cycle(0, 0, 0, 0);
    chk("mid_sweep_addr", int'(addr_o), 12);
    do_reset();
    cycle(1, 0, 0, 0);
    chk("post_reset_grant", int'(addr_o), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit av = ($urandom_range(99) < 60);
      bit fv = ($urandom_range(99) < 30);
      bit fl = ($urandom_range(199) < 2);
      cycle(av, fv, int'($urandom_range(31)), fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
